id_ex_stage: RTL and testbench

ID_EX_STAGE -- requirements
Module: id_ex_stage

---
 rtl/id_ex_stage_pkg.sv | 21 ++
 rtl/id_ex_stage_fwd_mux.sv | 24 ++
 rtl/id_ex_stage.sv | 89 ++++++++
 tb/tb_id_ex_stage.sv | 166 ++++++++++++++++
 4 files changed

// File: rtl/id_ex_stage_pkg.sv
// id_ex_stage_pkg: shared core widths and helpers for the ID/EX pipeline register.
`ifndef REG_W
`define REG_W 5
`endif
`ifndef DATA_W
`define DATA_W 16
`endif
`ifndef REG
`define REG 32
`endif
`ifndef REG_STACK
`define REG_STACK 29
`endif
package id_ex_stage_pkg;
  localparam int REG_W_D = `REG_W;
  localparam int DATA_W_D = `DATA_W;
  localparam int CNT_W = 16;
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (c == {CNT_W{1'b1}}) ? c : c + 1'b1;
  endfunction
endpackage

// File: rtl/id_ex_stage_fwd_mux.sv
// fwd_mux: picks one source operand from register zero, EX result, MEM result or register file.
module fwd_mux #(
  parameter int REG_W = `REG_W,
  parameter int DATA_W = `DATA_W
) (
  input  logic [REG_W-1:0]  idx,
  input  logic [DATA_W-1:0] rd,
  input  logic              ex_ld,
  input  logic              exf_we,
  input  logic [REG_W-1:0]  exf_a3,
  input  logic [DATA_W-1:0] exf_res,
  input  logic              memf_we,
  input  logic [REG_W-1:0]  memf_a3,
  input  logic [DATA_W-1:0] memf_res,
  output logic [DATA_W-1:0] op
);
  logic ex_hit, mem_hit;
  // A load in EX has no data yet; the load-use stall handles it instead.
  always_comb begin
    ex_hit = exf_we & ~ex_ld & (exf_a3 == idx);
    mem_hit = memf_we & (memf_a3 == idx);
    op = (idx == '0) ? '0 : ex_hit ? exf_res : mem_hit ? memf_res : rd;
  end
endmodule

// File: rtl/id_ex_stage.sv
// id_ex_stage: ID/EX pipeline register with operand forwarding, load-use stall and flush.
module id_ex_stage
  import id_ex_stage_pkg::*;
#(
  parameter int REG_W = `REG_W,
  parameter int DATA_W = `DATA_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              id_valid,
  input  logic [REG_W-1:0]  id_a1,
  input  logic [REG_W-1:0]  id_a2,
  input  logic [REG_W-1:0]  id_a3,
  input  logic              id_use1,
  input  logic              id_use2,
  input  logic              id_we,
  input  logic              id_ld,
  input  logic [DATA_W-1:0] rd1,
  input  logic [DATA_W-1:0] rd2,
  input  logic              exf_we,
  input  logic [REG_W-1:0]  exf_a3,
  input  logic [DATA_W-1:0] exf_res,
  input  logic              memf_we,
  input  logic [REG_W-1:0]  memf_a3,
  input  logic [DATA_W-1:0] memf_res,
  input  logic              flush,
  output logic              stall,
  output logic              ex_valid,
  output logic              ex_we,
  output logic              ex_ld,
  output logic [REG_W-1:0]  ex_a3,
  output logic [DATA_W-1:0] ex_op1,
  output logic [DATA_W-1:0] ex_op2,
  output logic [CNT_W-1:0]  stall_cnt
);
  logic ex_valid_q, ex_we_q, ex_ld_q, ex_valid_d, ex_we_d, ex_ld_d, bubble;
  logic [REG_W-1:0] ex_a3_q, ex_a3_d;
  logic [DATA_W-1:0] ex_op1_q, ex_op2_q, ex_op1_d, ex_op2_d, fwd1, fwd2;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  fwd_mux #(.REG_W(REG_W), .DATA_W(DATA_W)) u_fwd1 (
    .idx(id_a1), .rd(rd1), .ex_ld(ex_ld_q),
    .exf_we(exf_we), .exf_a3(exf_a3), .exf_res(exf_res),
    .memf_we(memf_we), .memf_a3(memf_a3), .memf_res(memf_res), .op(fwd1)
  );
  fwd_mux #(.REG_W(REG_W), .DATA_W(DATA_W)) u_fwd2 (
    .idx(id_a2), .rd(rd2), .ex_ld(ex_ld_q),
    .exf_we(exf_we), .exf_a3(exf_a3), .exf_res(exf_res),
    .memf_we(memf_we), .memf_a3(memf_a3), .memf_res(memf_res), .op(fwd2)
  );
  // Flush masks the stall, so flush+stall yields one bubble and no count.
  always_comb begin
    stall = id_valid & ~flush & ex_valid_q & ex_ld_q & (|ex_a3_q)
          & ((id_use1 & (id_a1 == ex_a3_q)) | (id_use2 & (id_a2 == ex_a3_q)));
    bubble = flush | stall | ~id_valid;
    ex_valid_d = ~bubble;
    ex_we_d = ~bubble & id_we;
    ex_ld_d = ~bubble & id_ld;
    ex_a3_d = bubble ? '0 : id_a3;
    ex_op1_d = bubble ? '0 : fwd1;
    ex_op2_d = bubble ? '0 : fwd2;
    stall_cnt_d = stall ? sat_inc(stall_cnt_q) : stall_cnt_q;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_valid_q <= 1'b0;
      ex_we_q <= 1'b0;
      ex_ld_q <= 1'b0;
      ex_a3_q <= '0;
      ex_op1_q <= '0;
      ex_op2_q <= '0;
      stall_cnt_q <= '0;
    end else begin
      ex_valid_q <= ex_valid_d;
      ex_we_q <= ex_we_d;
      ex_ld_q <= ex_ld_d;
      ex_a3_q <= ex_a3_d;
      ex_op1_q <= ex_op1_d;
      ex_op2_q <= ex_op2_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end
  assign ex_valid = ex_valid_q;
  assign ex_we = ex_we_q;
  assign ex_ld = ex_ld_q;
  assign ex_a3 = ex_a3_q;
  assign ex_op1 = ex_op1_q;
  assign ex_op2 = ex_op2_q;
  assign stall_cnt = stall_cnt_q;
endmodule

// File: tb/tb_id_ex_stage.sv
// tb_id_ex_stage: scoreboard bench for id_ex_stage covering forwarding, load-use, flush and reset.
module tb_id_ex_stage;
  import id_ex_stage_pkg::*;
  localparam int RW = REG_W_D;
  localparam int DW = DATA_W_D;
  typedef struct packed {
    logic v, we, ld;
    logic [RW-1:0] a3;
    logic [DW-1:0] o1, o2;
  } ex_t;
  logic clk = 1'b0, rst_n = 1'b0;
  logic id_valid, id_use1, id_use2, id_we, id_ld, exf_we, memf_we, flush;
  logic [RW-1:0] id_a1, id_a2, id_a3, exf_a3, memf_a3;
  logic [DW-1:0] rd1, rd2, exf_res, memf_res;
  logic stall, ex_valid, ex_we, ex_ld;
  logic [RW-1:0] ex_a3;
  logic [DW-1:0] ex_op1, ex_op2;
  logic [15:0] stall_cnt;
  ex_t sb[$];
  ex_t m = '0;
  logic [15:0] cnt = '0;
  int checks = 0, errors = 0;
  always #5 clk = ~clk;
  id_ex_stage dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_a1(id_a1), .id_a2(id_a2),
    .id_a3(id_a3), .id_use1(id_use1), .id_use2(id_use2), .id_we(id_we), .id_ld(id_ld),
    .rd1(rd1), .rd2(rd2), .exf_we(exf_we), .exf_a3(exf_a3), .exf_res(exf_res),
    .memf_we(memf_we), .memf_a3(memf_a3), .memf_res(memf_res), .flush(flush),
    .stall(stall), .ex_valid(ex_valid), .ex_we(ex_we), .ex_ld(ex_ld), .ex_a3(ex_a3),
    .ex_op1(ex_op1), .ex_op2(ex_op2), .stall_cnt(stall_cnt)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask
  task automatic clr_in();
    {id_valid, id_use1, id_use2, id_we, id_ld, exf_we, memf_we, flush} = '0;
    {id_a1, id_a2, id_a3, exf_a3, memf_a3} = '0;
    {rd1, rd2, exf_res, memf_res} = '0;
  endtask
  function automatic logic [DW-1:0] fwd(input logic [RW-1:0] idx, input logic [DW-1:0] rd);
    if (idx == 0) return '0;
    if (exf_we && !m.ld && exf_a3 == idx) return exf_res;
    if (memf_we && memf_a3 == idx) return memf_res;
    return rd;
  endfunction
  task automatic chk_zero(input string tag);
    chk({tag, "_valid"}, ex_valid, 0);
    chk({tag, "_we"}, ex_we, 0);
    chk({tag, "_ld"}, ex_ld, 0);
    chk({tag, "_a3"}, ex_a3, 0);
    chk({tag, "_op1"}, ex_op1, 0);
    chk({tag, "_op2"}, ex_op2, 0);
    chk({tag, "_cnt"}, stall_cnt, 0);
  endtask
  task automatic cycle(input string tag);
    ex_t e;
    logic es;
    #1;
    es = id_valid && !flush && m.v && m.ld && m.a3 != 0 &&
         ((id_use1 && id_a1 == m.a3) || (id_use2 && id_a2 == m.a3));
    chk({tag, "_stall"}, stall, es);
    if (flush || es || !id_valid) e = '0;
    else e = '{1'b1, id_we, id_ld, id_a3, fwd(id_a1, rd1), fwd(id_a2, rd2)};
    sb.push_back(e);
    if (es && cnt != 16'hFFFF) cnt++;
    @(posedge clk);
    #1;
    e = sb.pop_front();
    chk({tag, "_valid"}, ex_valid, e.v);
    chk({tag, "_we"}, ex_we, e.we);
    chk({tag, "_ld"}, ex_ld, e.ld);
    chk({tag, "_a3"}, ex_a3, e.a3);
    chk({tag, "_op1"}, ex_op1, e.o1);
    chk({tag, "_op2"}, ex_op2, e.o2);
    chk({tag, "_cnt"}, stall_cnt, cnt);
    m = e;
  endtask
  task automatic load_r(input logic [RW-1:0] r);
    clr_in();
    {id_valid, id_we, id_ld, id_use1} = 4'b1111;
    id_a1 = 1; id_a3 = r; rd1 = 16'h0101;
  endtask
  initial begin
    clr_in();
    repeat (2) @(posedge clk);
    #1;
    chk_zero("rst");
    rst_n = 1'b1;
    clr_in();
    {id_valid, id_use1, exf_we, id_we} = 4'b1111;
    id_a1 = 3; id_a3 = 4; exf_a3 = 3; exf_res = 16'h1234; rd1 = 16'h1111;
    cycle("exfwd");
    chk("exfwd_val", ex_op1, 16'h1234);
    clr_in();
    {id_valid, id_use2, exf_we, memf_we} = 4'b1111;
    id_a2 = 5; exf_a3 = 5; memf_a3 = 5; exf_res = 16'hAAAA; memf_res = 16'hBBBB; rd2 = 16'h2222;
    cycle("prio");
    chk("prio_val", ex_op2, 16'hAAAA);
    clr_in();
    {id_valid, id_use2, memf_we} = 3'b111;
    id_a2 = 6; memf_a3 = 6; memf_res = 16'hCCCC;
    cycle("memfwd");
    load_r(7);
    cycle("ld7");
    clr_in();
    {id_valid, id_use1, exf_we} = 3'b111;
    id_a1 = 7; exf_a3 = 7; exf_res = 16'hDEAD; rd1 = 16'h9999;
    cycle("ldstall");
    chk("ldstall_cnt1", stall_cnt, 1);
    exf_we = 0; memf_we = 1; memf_a3 = 7; memf_res = 16'h0055;
    cycle("ldmem");
    chk("ldmem_val", ex_op1, 16'h0055);
    load_r(0);
    cycle("ld0");
    clr_in();
    {id_valid, id_use1, exf_we} = 3'b111;
    exf_res = 16'hFFFF; rd1 = 16'h7777;
    cycle("r0");
    chk("r0_val", ex_op1, 0);
    load_r(7);
    cycle("ld7b");
    clr_in();
    {id_valid, id_use1, flush} = 3'b111;
    id_a1 = 7;
    cycle("flush");
    chk("flush_cnt", stall_cnt, 1);
    load_r(7);
    cycle("ld7c");
    clr_in();
    {id_valid, id_use2, id_we} = 3'b111;
    id_a2 = 7; id_a3 = 2;
    rst_n = 1'b0;
    #1;
    chk_zero("midrst");
    chk("midrst_stall", stall, 0);
    sb.delete();
    m = '0;
    cnt = '0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    cycle("postrst");
    for (int i = 0; i < 300; i++) begin
      id_valid = ($urandom_range(0, 3) != 0);
      {id_use1, id_use2, id_we} = 3'($urandom);
      id_ld = ($urandom_range(0, 2) == 0);
      flush = ($urandom_range(0, 7) == 0);
      id_a1 = RW'($urandom_range(0, 3));
      id_a2 = RW'($urandom_range(0, 3));
      id_a3 = RW'($urandom_range(0, 3));
      exf_we = 1'($urandom);
      memf_we = 1'($urandom);
      exf_a3 = RW'($urandom_range(0, 3));
      memf_a3 = RW'($urandom_range(0, 3));
      rd1 = DW'($urandom); rd2 = DW'($urandom);
      exf_res = DW'($urandom); memf_res = DW'($urandom);
      cycle("rnd");
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
